// File: rtl/fpu_pkg.sv
// Shared FPU definitions: divider latency, tag width and the divider result record
// buffered by the issue/retire sequencer.
package fpu_pkg;

  localparam int FDIV_LAT  = 7;
  localparam int FPU_TAG_W = 5;

  typedef struct packed {
    logic [31:0]          y;
    logic [FPU_TAG_W-1:0] tag;
    logic                 dz;
  } fdiv_res_t;

  // Zero or denormal binary32: exponent field all zeros.
  function automatic logic exp_is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fpu_fifo.sv
// Synchronous first-word-fall-through FIFO for divider results; the head entry is
// visible whenever the FIFO is non-empty and reads as zero when empty.
module fpu_fifo
  import fpu_pkg::*;
#(
  parameter int WIDTH = $bits(fdiv_res_t),
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the count qualifies every entry, so
  // clearing it would only add reset fan-out to a RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fdiv_seq.sv
// Issue/retire sequencer for the fixed-latency divider: handshakes requests in,
// tracks them with a latency-aligned tag pipe and retires quotients through a FIFO.
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int LAT   = FDIV_LAT,
  parameter int DEPTH = 8,
  parameter int TAG_W = FPU_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x1,
  input  logic [31:0]      in_x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_x1,
  output logic [31:0]      div_x2,
  input  logic [31:0]      div_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dz
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } slot_t;

  slot_t            sr [LAT];
  logic [CNT_W-1:0] outstanding;
  logic             accept;
  logic             pop;
  fdiv_res_t        wr_res;
  fdiv_res_t        rd_res;

  // Credits cover in-flight ops plus buffered results, so a retiring quotient
  // always finds a free FIFO slot.
  assign in_ready = (outstanding < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outstanding <= '0;
      div_x1      <= '0;
      div_x2      <= '0;
      for (int i = 0; i < LAT; i++) sr[i] <= '0;
    end else begin
      if (accept) begin
        div_x1 <= in_x1;
        div_x2 <= in_x2;
      end
      sr[0] <= '{valid: accept, tag: in_tag, dz: exp_is_zero(in_x2)};
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
      if (accept && !pop)      outstanding <= outstanding + 1'b1;
      else if (pop && !accept) outstanding <= outstanding - 1'b1;
    end
  end

  assign wr_res = '{y: div_y, tag: FPU_TAG_W'(sr[LAT-1].tag), dz: sr[LAT-1].dz};

  fpu_fifo #(
    .WIDTH ($bits(fdiv_res_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (sr[LAT-1].valid),
    .wr_data  (wr_res),
    .rd_en    (out_ready),
    .rd_valid (out_valid),
    .rd_data  (rd_res)
  );

  assign out_y   = rd_res.y;
  assign out_tag = TAG_W'(rd_res.tag);
  assign out_dz  = rd_res.dz;

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: a behavioural 7-edge divider plus a transaction
// model (credit count, latency pipe, result queue) checked every cycle.
module tb_fdiv_seq;
  import fpu_pkg::*;

  localparam int LAT   = 7;
  localparam int DEPTH = 8;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_x1;
  logic [31:0]      in_x2;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      div_x1;
  logic [31:0]      div_x2;
  logic [31:0]      div_y;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;

  always #5 clk = ~clk;

  fdiv_seq #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_tag    (in_tag),
    .div_x1    (div_x1),
    .div_x2    (div_x2),
    .div_y     (div_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_dz    (out_dz)
  );

  // Stand-in quotient: exact for the 6.0/2.0 case, a unique bit mix otherwise.
  function automatic logic [31:0] fake_div(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  // Divider: result of operands loaded at edge E is presented for the sample at E+LAT.
  logic [31:0] dpipe [LAT-1];
  always @(posedge clk) begin
    dpipe[0] <= fake_div(div_x1, div_x2);
    for (int i = 1; i < LAT - 1; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_y = dpipe[LAT-2];

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [31:0]      x1;
    logic [31:0]      x2;
  } mop_t;

  mop_t m_sr [LAT];
  mop_t mq [$];
  int   m_cnt = 0;
  int   total = 0;
  int   bad   = 0;
  int   idx, got, acc_cnt, n;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock edge; the model follows the handshakes it predicts.
  task automatic step();
    logic acc;
    logic pp;
    acc = in_valid && (m_cnt < DEPTH);
    pp  = (mq.size() > 0) && out_ready;
    @(posedge clk);
    if (!rstn) begin
      m_cnt = 0;
      mq.delete();
      for (int i = 0; i < LAT; i++) m_sr[i] = '0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (m_sr[LAT-1].v) mq.push_back(m_sr[LAT-1]);
      for (int i = LAT - 1; i > 0; i--) m_sr[i] = m_sr[i-1];
      m_sr[0] = '{v: acc, tag: in_tag, x1: in_x1, x2: in_x2};
      m_cnt = m_cnt + int'(acc) - int'(pp);
    end
    #1;
  endtask

  task automatic check_all();
    check("in_ready", 32'(in_ready), 32'(m_cnt < DEPTH));
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("out_y", out_y, fake_div(mq[0].x1, mq[0].x2));
      check("out_tag", 32'(out_tag), 32'(mq[0].tag));
      check("out_dz", 32'(out_dz), 32'(mq[0].x2[30:23] == 8'd0));
    end else begin
      check("out_y_empty", out_y, 0);
      check("out_tag_empty", 32'(out_tag), 0);
      check("out_dz_empty", 32'(out_dz), 0);
    end
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_x1 = '0; in_x2 = '0; in_tag = '0; out_ready = 1'b0;
    step(); step();
    rstn = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_div_x1", div_x1, 0);
    check("rst_div_x2", div_x2, 0);
    check_all();

    // Single op 6.0 / 2.0, tag 3: valid exactly 8 cycles after the handshake cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_x1 = 32'h40C00000; in_x2 = 32'h40000000; in_tag = 5'd3;
    check_all();
    step();
    in_valid = 1'b0;
    check("t1_div_x1", div_x1, 32'h40C00000);
    check("t1_div_x2", div_x2, 32'h40000000);
    for (int k = 1; k < 8; k++) begin
      check("t1_early", 32'(out_valid), 0);
      check_all();
      step();
    end
    check("t1_valid", 32'(out_valid), 1);
    check("t1_y", out_y, 32'h40400000);
    check("t1_tag", 32'(out_tag), 3);
    check("t1_dz", 32'(out_dz), 0);
    check_all();
    step();
    check("t1_popped", 32'(out_valid), 0);
    check_all();

    // 20 streamed ops, tags 0..19, results must retire in tag order
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 20; cyc++) begin
      in_valid = (idx < 20);
      in_x1    = 32'h3F800000 + (32'(idx) << 12);
      in_x2    = 32'h40000000 + 32'(idx);
      in_tag   = TAG_W'(idx);
      check_all();
      if (out_valid) begin
        check("t2_order", 32'(out_tag), 32'(got));
        got++;
      end
      if (in_valid && m_cnt < DEPTH) idx++;
      step();
    end
    in_valid = 1'b0;
    check("t2_count", 32'(got), 20);
    for (int k = 0; k < 10; k++) begin check_all(); step(); end

    // Back-pressure: exactly DEPTH accepts, then in_ready falls
    out_ready = 1'b0; in_valid = 1'b1; acc_cnt = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_x1 = 32'h41000000 + 32'(cyc); in_x2 = 32'h3F800000; in_tag = TAG_W'(cyc);
      check_all();
      if (in_ready) acc_cnt++;
      step();
    end
    check("t3_accepts", 32'(acc_cnt), 8);
    check("t3_ready_low", 32'(in_ready), 0);
    check("t3_full_valid", 32'(out_valid), 1);

    // outstanding=8: pop happens, accept is blocked
    out_ready = 1'b1; in_x1 = 32'h41A00000; in_tag = 5'd21;
    check("t5_blocked", 32'(in_ready), 0);
    check_all();
    step();
    out_ready = 1'b0;
    check("t3_reraise", 32'(in_ready), 1);
    check_all();
    // outstanding=7: accept and pop together leave it at 7
    out_ready = 1'b1; in_x1 = 32'h41B00000; in_tag = 5'd22;
    step();
    out_ready = 1'b0;
    check("t5_both_ready", 32'(in_ready), 1);
    check_all();
    in_x1 = 32'h41C00000; in_tag = 5'd23;
    step();
    check("t5_count_was7", 32'(in_ready), 0);
    check_all();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin check_all(); step(); end
    check("t3_drained", 32'(out_valid), 0);

    // dz flag: zero divisor sets it, smallest normal divisor does not
    in_valid = 1'b1; in_x1 = 32'h3F800000; in_x2 = 32'h00000000; in_tag = 5'd7;
    check_all();
    step();
    in_x2 = 32'h00800000; in_tag = 5'd8;
    step();
    in_valid = 1'b0; n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      check_all();
      if (out_valid) begin
        if (n == 0) begin
          check("t4_tag0", 32'(out_tag), 7);
          check("t4_dz0", 32'(out_dz), 1);
        end else begin
          check("t4_tag1", 32'(out_tag), 8);
          check("t4_dz1", 32'(out_dz), 0);
        end
        n++;
      end
      step();
    end
    check("t4_count", 32'(n), 2);

    // Reset with 2 buffered and 5 in flight
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_x1 = 32'h42000000 + 32'(i); in_x2 = 32'h3F800000; in_tag = TAG_W'(10 + i);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    check("t6_buffered", 32'(out_valid), 1);
    check_all();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("t6_stale", 32'(out_valid), 0);
      check_all();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
